// File: rtl/uart_rx_oversample_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample_pkg
// Shared definitions for the oversampling UART receiver: FSM state encoding,
// default line/clock rates and the tick-divider calculation, which is also
// used by the transmitter side so that both derive the same sample strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_rx_oversample_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int DEF_CLK_RATE    = 9600000;
    localparam int DEF_BAUD_RATE   = 19200;
    localparam int DEF_SAMPLE_RATE = 10;
    localparam int DEF_DATA_BITS   = 8;

    // System clocks per sample strobe.
    function automatic int calc_tick_div(input int clk_rate, input int baud_rate,
                                         input int sample_rate);
        return clk_rate / (baud_rate * sample_rate);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_tick_gen
// Sample-strobe generator: counts 0..TICK_DIV-1 and flags the last count.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous reset, active low
//   i_clr        synchronous clear, counter restarts from 0 next cycle
//   o_sample_en  high during the cycle the counter holds TICK_DIV-1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_tick_gen
    import uart_rx_oversample_pkg::*;
#(
    parameter int TICK_DIV = calc_tick_div(DEF_CLK_RATE, DEF_BAUD_RATE, DEF_SAMPLE_RATE)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_sample_en
);

    localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sample_en = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
// 8N1-style UART receiver with SAMPLE_RATE x oversampling and a 3-sample
// majority vote around mid-bit.
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active low
//   rx         serial line, idle high, asynchronous to clk
//   rx_data    last received payload, held until the next frame completes
//   rx_valid   one-cycle pulse, rx_data is a good byte
//   frame_err  one-cycle pulse, stop bit voted low (rx_data still updated)
//   busy       high from start-edge detection until return to idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_oversample
    import uart_rx_oversample_pkg::*;
#(
    parameter int CLK_RATE    = DEF_CLK_RATE,
    parameter int BAUD_RATE   = DEF_BAUD_RATE,
    parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
    parameter int DATA_BITS   = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int         TICK_DIV = calc_tick_div(CLK_RATE, BAUD_RATE, SAMPLE_RATE);
    localparam int         M        = SAMPLE_RATE / 2;
    localparam logic [3:0] S_LAST   = 4'(SAMPLE_RATE - 1);
    localparam logic [3:0] S_V0     = 4'(M - 1);
    localparam logic [3:0] S_V1     = 4'(M);
    localparam logic [3:0] S_V2     = 4'(M + 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic [4:0] BRK_LAST = 5'(SAMPLE_RATE - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("uart_rx_oversample: TICK_DIV must be >= 2");
    end
    if ((CLK_RATE % (BAUD_RATE * SAMPLE_RATE)) != 0) begin : g_bad_tick_frac
        $error("uart_rx_oversample: CLK_RATE must be a multiple of BAUD_RATE*SAMPLE_RATE");
    end
    if ((SAMPLE_RATE < 4) || (SAMPLE_RATE > 16)) begin : g_bad_sample_rate
        $error("uart_rx_oversample: SAMPLE_RATE must be 4..16");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
        $error("uart_rx_oversample: DATA_BITS must be 5..8");
    end

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                 r_rx_meta;
    logic                 r_rx_s;
    rx_state_t            r_state;
    logic [3:0]           r_s;
    logic [2:0]           r_bit;
    logic [1:0]           r_vote;
    logic [DATA_BITS-1:0] r_shift;
    logic [4:0]           r_brk;

    logic w_sample_en;
    logic w_tick_clr;
    logic w_vote_done;
    logic w_wrap;
    logic w_bit;

    // Restart the sample grid on the cycle the start edge is seen.
    assign w_tick_clr  = (r_state == ST_IDLE) && !r_rx_s;
    assign w_vote_done = w_sample_en && (r_s == S_V2);
    assign w_wrap      = w_sample_en && (r_s == S_LAST);
    // Third vote sample is the one being taken right now.
    assign w_bit       = maj3(r_vote[1], r_vote[0], r_rx_s);

    uart_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_clr       (w_tick_clr),
        .o_sample_en (w_sample_en)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Sample index within the bit; held at 0 while idle so a new frame
    // always starts from s=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s <= '0;
        end else if (r_state == ST_IDLE) begin
            r_s <= '0;
        end else if (w_sample_en) begin
            r_s <= (r_s == S_LAST) ? 4'd0 : r_s + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vote <= '0;
        end else if (w_sample_en && ((r_s == S_V0) || (r_s == S_V1))) begin
            r_vote <= {r_vote[0], r_rx_s};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bit     <= '0;
            r_shift   <= '0;
            r_brk     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit <= '0;
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    // A start bit that votes high was a glitch.
                    if (w_vote_done && w_bit) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_wrap) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_vote_done) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_wrap) begin
                        if (r_bit == BIT_LAST) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // Leave mid-bit so the next start edge can be caught
                    // even when frames run back to back.
                    if (w_vote_done) begin
                        rx_data <= r_shift;
                        if (w_bit) begin
                            rx_valid <= 1'b1;
                            r_state  <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= ST_BREAK;
                            r_brk     <= '0;
                        end
                    end
                end
                ST_BREAK: begin
                    // Need a full bit time of consecutive high samples.
                    if (w_sample_en) begin
                        if (!r_rx_s) begin
                            r_brk <= '0;
                        end else if (r_brk == BRK_LAST) begin
                            r_brk   <= '0;
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_brk <= r_brk + 5'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversample
// Drives serial frames into uart_rx_oversample (160 clk per nominal bit) and
// compares every rx_valid / frame_err event against the frames the bench
// itself sent.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_oversample;

    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Events are {is_error, data}.
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] model_last = 8'h00;
    int         n_both = 0;
    int         n_wide = 0;
    logic       busy_seen = 1'b0;
    logic       prev_v = 1'b0;
    logic       prev_e = 1'b0;

    uart_rx_oversample #(
        .CLK_RATE    (160),
        .BAUD_RATE   (1),
        .SAMPLE_RATE (10),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid)  got_q.push_back({1'b0, rx_data});
            if (frame_err) got_q.push_back({1'b1, rx_data});
            if (rx_valid && frame_err) n_both++;
            if ((rx_valid && prev_v) || (frame_err && prev_e)) n_wide++;
            if (busy) busy_seen = 1'b1;
        end
        prev_v = rx_valid;
        prev_e = frame_err;
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_v);
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(b[i], bclk);
        drive(stop_v, bclk);
    endtask

    task automatic expect_ok(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
        model_last = b;
    endtask

    task automatic expect_err(input logic [7:0] b);
        exp_q.push_back({1'b1, b});
        model_last = b;
    endtask

    // Idle the line, wait (bounded) for the receiver to go idle, then
    // compare everything observed during the scenario.
    task automatic end_scn(input string tag);
        int waited;
        int n;
        waited = 0;
        rx = 1'b1;
        repeat (40) @(negedge clk);
        while (busy && (waited < 4000)) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        chk_val({tag, " busy_idle"}, 32'(busy), 32'd0);
        chk_val({tag, " n_events"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk_val({tag, " event"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        chk_val({tag, " valid_and_err"}, 32'(n_both), 32'd0);
        chk_val({tag, " pulse_width"}, 32'(n_wide), 32'd0);
        chk_val({tag, " data_hold"}, 32'(rx_data), 32'(model_last));
        got_q.delete();
        exp_q.delete();
        n_both = 0;
        n_wide = 0;
    endtask

    initial begin
        logic [7:0] b;
        int         bclk;
        int         gap;

        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk_val("reset rx_data", 32'(rx_data), 32'd0);
        chk_val("reset rx_valid", 32'(rx_valid), 32'd0);
        chk_val("reset frame_err", 32'(frame_err), 32'd0);
        chk_val("reset busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Single ideal frame.
        send_frame(8'hA5, BIT_CLK, 1'b1);
        expect_ok(8'hA5);
        end_scn("a5");

        // Back to back, no idle gap.
        send_frame(8'h00, BIT_CLK, 1'b1);
        send_frame(8'hFF, BIT_CLK, 1'b1);
        send_frame(8'h55, BIT_CLK, 1'b1);
        expect_ok(8'h00);
        expect_ok(8'hFF);
        expect_ok(8'h55);
        end_scn("b2b");

        // Short low glitch: receiver wakes up, then rejects the start bit.
        busy_seen = 1'b0;
        drive(1'b0, 40);
        end_scn("glitch");
        chk_val("glitch busy_seen", 32'(busy_seen), 32'd1);

        // One-sample spike in the middle of bit 3 of 0x00.
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 3; i++) drive(1'b0, BIT_CLK);
        drive(1'b0, 89);
        drive(1'b1, 16);
        drive(1'b0, 55);
        for (int i = 4; i < 8; i++) drive(1'b0, BIT_CLK);
        drive(1'b1, BIT_CLK);
        expect_ok(8'h00);
        end_scn("spike");

        // Framing error, then recovery.
        send_frame(8'h3C, BIT_CLK, 1'b0);
        drive(1'b1, 400);
        send_frame(8'h81, BIT_CLK, 1'b1);
        expect_err(8'h3C);
        expect_ok(8'h81);
        end_scn("ferr");

        // Reset in the middle of 0x12's data bits.
        drive(1'b0, BIT_CLK);
        drive(1'b0, BIT_CLK);
        drive(1'b1, BIT_CLK);
        drive(1'b0, 80);
        rst = 1'b0;
        #1;
        chk_val("midrst rx_data", 32'(rx_data), 32'd0);
        chk_val("midrst rx_valid", 32'(rx_valid), 32'd0);
        chk_val("midrst frame_err", 32'(frame_err), 32'd0);
        chk_val("midrst busy", 32'(busy), 32'd0);
        model_last = 8'h00;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h34, BIT_CLK, 1'b1);
        expect_ok(8'h34);
        end_scn("midrst");

        // Baud skew of about -3% and +3%.
        send_frame(8'hC3, 155, 1'b1);
        expect_ok(8'hC3);
        end_scn("skew_fast");
        send_frame(8'hC3, 165, 1'b1);
        expect_ok(8'hC3);
        end_scn("skew_slow");

        // Line stuck low after a frame: exactly one framing error.
        b = 8'($urandom);
        send_frame(b, BIT_CLK, 1'b0);
        drive(1'b0, 3000);
        expect_err(b);
        end_scn("stuck");

        // Random bytes, random bit period and gap.
        for (int k = 0; k < 5; k++) begin
            b    = 8'($urandom);
            bclk = int'($urandom_range(155, 165));
            gap  = int'($urandom_range(20, 200));
            send_frame(b, bclk, 1'b1);
            expect_ok(b);
            drive(1'b1, gap);
        end
        end_scn("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
